// File: rtl/ctrl_blk_param.sv
// ctrl_blk_param: serial word framer plus header/payload packet FSM driving a FIFO write port.
// Defining CTRL_BLK_CHECKSUM_EN adds a trailing checksum word after the payload.
module ctrl_blk_param #(
  parameter int                DATA_W        = 8,
  parameter logic [DATA_W-1:0] HDR_TEMP      = 8'hA5,
  parameter logic [DATA_W-1:0] HDR_CHECK     = 8'hC3,
  parameter int                PAYLOAD_BYTES = 4,
  parameter bit                MSB_FIRST     = 1'b1
) (
  input  logic              clk_50,
  input  logic              reset,
  input  logic              serial_data,
  input  logic              data_ena,
  input  logic              fifo_full,
  output logic              wr_fifo,
  output logic [DATA_W-1:0] fifo_data,
  output logic              byte_assembled,
  output logic [1:0]        pkt_type,
  output logic              pkt_done,
  output logic              frame_err,
  output logic              ovf_err,
  output logic              chk_err
);
  localparam int CW = $clog2(DATA_W + 2);

  typedef enum logic [1:0] {HEADER, PAYLOAD, CHECKSUM} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] shreg;
  logic [CW-1:0]     bit_cnt;
  logic              ena_d, fall, good, last;
  logic [7:0]        byte_cnt, byte_cnt_nx;
  logic              wr_nx, ba_nx, done_nx, ferr_nx, ovf_nx;
  logic [1:0]        type_nx;
  logic [DATA_W-1:0] data_nx;
`ifdef CTRL_BLK_CHECKSUM_EN
  logic [DATA_W-1:0] sum, sum_nx;
  logic              chk_nx;
`endif

  // a word ends on the first idle sample after data_ena was high
  assign fall = ~data_ena & ena_d;
  assign good = fall && (bit_cnt == CW'(DATA_W));
  assign last = (byte_cnt == 8'(PAYLOAD_BYTES - 1));

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state          <= HEADER;
      shreg          <= '0;
      bit_cnt        <= '0;
      ena_d          <= 1'b0;
      byte_cnt       <= '0;
      wr_fifo        <= 1'b0;
      fifo_data      <= '0;
      byte_assembled <= 1'b0;
      pkt_type       <= 2'b00;
      pkt_done       <= 1'b0;
      frame_err      <= 1'b0;
      ovf_err        <= 1'b0;
    end else begin
      state <= state_nx;
      ena_d <= data_ena;
      if (data_ena) begin
        if (MSB_FIRST) shreg <= {shreg[DATA_W-2:0], serial_data};
        else           shreg <= {serial_data, shreg[DATA_W-1:1]};
      end
      if (fall)
        bit_cnt <= '0;
      else if (data_ena && bit_cnt != CW'(DATA_W + 1))
        bit_cnt <= bit_cnt + 1'b1;
      byte_cnt       <= byte_cnt_nx;
      wr_fifo        <= wr_nx;
      fifo_data      <= data_nx;
      byte_assembled <= ba_nx;
      pkt_type       <= type_nx;
      pkt_done       <= done_nx;
      frame_err      <= ferr_nx;
      ovf_err        <= ovf_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (fall) begin
      if (!good) state_nx = HEADER;
      else begin
        case (state)
          HEADER:   if (shreg == HDR_TEMP || shreg == HDR_CHECK) state_nx = PAYLOAD;
`ifdef CTRL_BLK_CHECKSUM_EN
          PAYLOAD:  if (last) state_nx = CHECKSUM;
`else
          PAYLOAD:  if (last) state_nx = HEADER;
`endif
          CHECKSUM: state_nx = HEADER;
          default:  state_nx = HEADER;
        endcase
      end
    end
  end

  always_comb begin
    wr_nx       = 1'b0;
    ba_nx       = 1'b0;
    done_nx     = 1'b0;
    ferr_nx     = 1'b0;
    data_nx     = fifo_data;
    type_nx     = pkt_type;
    ovf_nx      = ovf_err;
    byte_cnt_nx = byte_cnt;
`ifdef CTRL_BLK_CHECKSUM_EN
    sum_nx = sum;
    chk_nx = 1'b0;
`endif
    if (fall) begin
      if (!good) begin
        ferr_nx     = 1'b0 | 1'b1;
        byte_cnt_nx = '0;
      end else begin
        ba_nx = 1'b1;
        case (state)
          HEADER: begin
            if (shreg == HDR_TEMP)       type_nx = 2'b01;
            else if (shreg == HDR_CHECK) type_nx = 2'b10;
            else                         type_nx = 2'b00;
            byte_cnt_nx = '0;
`ifdef CTRL_BLK_CHECKSUM_EN
            sum_nx = shreg;
`endif
          end
          PAYLOAD: begin
            // dropped words still count toward the packet length
            if (!fifo_full) begin
              wr_nx   = 1'b1;
              data_nx = shreg;
            end else begin
              ovf_nx = 1'b1;
            end
            byte_cnt_nx = last ? '0 : byte_cnt + 8'd1;
`ifdef CTRL_BLK_CHECKSUM_EN
            sum_nx = sum + shreg;
`else
            done_nx = last;
`endif
          end
          CHECKSUM: begin
`ifdef CTRL_BLK_CHECKSUM_EN
            done_nx = 1'b1;
            chk_nx  = (shreg != sum);
`endif
          end
          default: ;
        endcase
      end
    end
  end

`ifdef CTRL_BLK_CHECKSUM_EN
  always_ff @(posedge clk_50) begin
    if (reset) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      sum     <= sum_nx;
      chk_err <= chk_nx;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_blk_param.sv
// Randomised and directed bench for ctrl_blk_param; a word-level packet model predicts every output each cycle.
module tb_ctrl_blk_param;
  localparam int PB = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, serial_data = 1'b0, data_ena = 1'b0, fifo_full = 1'b0;
  logic wr_fifo, byte_assembled, pkt_done, frame_err, ovf_err, chk_err;
  logic [7:0] fifo_data;
  logic [1:0] pkt_type;
  logic ser16 = 1'b0, ena16 = 1'b0;
  logic wr16, ba16, done16, ferr16, ovf16, chk16;
  logic [15:0] data16;
  logic [1:0] type16;

  always #10 clk = ~clk;

  ctrl_blk_param #(.DATA_W(8), .HDR_TEMP(8'hA5), .HDR_CHECK(8'hC3), .PAYLOAD_BYTES(PB), .MSB_FIRST(1'b1)) dut (
    .clk_50(clk), .reset(reset), .serial_data(serial_data), .data_ena(data_ena), .fifo_full(fifo_full),
    .wr_fifo(wr_fifo), .fifo_data(fifo_data), .byte_assembled(byte_assembled), .pkt_type(pkt_type),
    .pkt_done(pkt_done), .frame_err(frame_err), .ovf_err(ovf_err), .chk_err(chk_err));

  ctrl_blk_param #(.DATA_W(16), .HDR_TEMP(16'h00A5), .HDR_CHECK(16'h00C3), .PAYLOAD_BYTES(2), .MSB_FIRST(1'b0)) dut16 (
    .clk_50(clk), .reset(reset), .serial_data(ser16), .data_ena(ena16), .fifo_full(1'b0),
    .wr_fifo(wr16), .fifo_data(data16), .byte_assembled(ba16), .pkt_type(type16),
    .pkt_done(done16), .frame_err(ferr16), .ovf_err(ovf16), .chk_err(chk16));

  typedef struct {
    int         cyc;
    bit         wr, ba, done, ferr, chk, ovf;
    logic [1:0] ptype;
    logic [7:0] fdata;
  } ev_t;

  ev_t  q[$];
  ev_t  lvl;
  int   cyc = 0, nvec = 0, nerr = 0;
  bit   chk_en = 1'b0;
  logic [7:0] wr_log[$];
  int   n_done = 0, n_ba = 0, n_ferr = 0, n_chk = 0;

  // model: packet position, running sum and sticky levels
  bit         m_in_pkt, m_want_sum;
  int         m_left;
  logic [7:0] m_sum, m_fdata;
  logic [1:0] m_ptype;
  bit         m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_in_pkt = 0; m_want_sum = 0; m_left = 0; m_sum = '0; m_fdata = '0; m_ptype = 2'b00; m_ovf = 0;
    q.delete();
    lvl.cyc = 0; lvl.wr = 0; lvl.ba = 0; lvl.done = 0; lvl.ferr = 0; lvl.chk = 0; lvl.ovf = 0;
    lvl.ptype = 2'b00; lvl.fdata = '0;
  endfunction

  function automatic void model_word(input logic [7:0] w, input int n, input bit full, input int tcyc);
    ev_t e;
    e.wr = 0; e.ba = 0; e.done = 0; e.ferr = 0; e.chk = 0;
    if (n != 8) begin
      e.ferr = 1; m_in_pkt = 0; m_want_sum = 0;
    end else begin
      e.ba = 1;
      if (m_want_sum) begin
        e.done = 1; e.chk = (w != m_sum); m_want_sum = 0;
      end else if (m_in_pkt) begin
        if (full) m_ovf = 1;
        else begin e.wr = 1; m_fdata = w; end
        m_sum = m_sum + w;
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_in_pkt = 0;
`ifdef CTRL_BLK_CHECKSUM_EN
          m_want_sum = 1;
`else
          e.done = 1;
`endif
        end
      end else begin
        m_ptype = (w == 8'hA5) ? 2'b01 : (w == 8'hC3) ? 2'b10 : 2'b00;
        m_in_pkt = (m_ptype != 2'b00);
        m_left = PB;
        m_sum = w;
      end
    end
    e.cyc = tcyc; e.ptype = m_ptype; e.ovf = m_ovf; e.fdata = m_fdata;
    q.push_back(e);
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    bit hit;
    if (chk_en) begin
      hit = 0;
      if (q.size() != 0 && q[0].cyc == cyc) begin
        lvl = q.pop_front();
        hit = 1;
      end
      check("wr_fifo", 32'(wr_fifo), 32'(hit && lvl.wr));
      check("byte_assembled", 32'(byte_assembled), 32'(hit && lvl.ba));
      check("pkt_done", 32'(pkt_done), 32'(hit && lvl.done));
      check("frame_err", 32'(frame_err), 32'(hit && lvl.ferr));
      check("chk_err", 32'(chk_err), 32'(hit && lvl.chk));
      check("pkt_type", 32'(pkt_type), 32'(lvl.ptype));
      check("ovf_err", 32'(ovf_err), 32'(lvl.ovf));
      check("fifo_data", 32'(fifo_data), 32'(lvl.fdata));
    end
    if (wr_fifo) wr_log.push_back(fifo_data);
    if (pkt_done) n_done++;
    if (byte_assembled) n_ba++;
    if (frame_err) n_ferr++;
    if (chk_err) n_chk++;
  end

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] w, input int n, input bit full);
    fifo_full = full;
    for (int i = 0; i < n; i++) begin
      data_ena = 1'b1;
      serial_data = (i < 8) ? w[7-i] : 1'($urandom);
      @(posedge clk); #1;
    end
    data_ena = 1'b0;
    model_word(w, n, full, cyc + 1);
    @(posedge clk); #1;
    fifo_full = 1'b0;
  endtask

  task automatic trailer(input logic [7:0] w);
`ifdef CTRL_BLK_CHECKSUM_EN
    send(w, 8, 1'b0);
`else
    if (w === 8'hxx) send(w, 8, 1'b0);
`endif
  endtask

  task automatic clear_logs();
    wr_log.delete(); n_done = 0; n_ba = 0; n_ferr = 0; n_chk = 0;
  endtask

  task automatic pkt1(input string tag);
    logic [7:0] exp_d[4];
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_logs();
    send(8'hA5, 8, 0); send(8'h11, 8, 0); send(8'h22, 8, 0); send(8'h33, 8, 0); send(8'h44, 8, 0);
    trailer(8'h4F);
    idle(2);
    check({tag, "_type"}, 32'(pkt_type), 32'h1);
    check({tag, "_nwr"}, 32'(wr_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < wr_log.size(); i++) check({tag, "_data"}, 32'(wr_log[i]), 32'(exp_d[i]));
    check({tag, "_done"}, 32'(n_done), 32'd1);
    check({tag, "_chk"}, 32'(n_chk), 32'd0);
  endtask

  task automatic send16(input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      ena16 = 1'b1; ser16 = w[i];
      @(posedge clk); #1;
    end
    ena16 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] w;
    int r, n;
    model_reset();
    idle(3);
    reset = 1'b0;
    chk_en = 1'b1;
    idle(1);
    check("rst_wr", 32'(wr_fifo), 32'h0);
    check("rst_type", 32'(pkt_type), 32'h0);
    check("rst_data", 32'(fifo_data), 32'h0);

    pkt1("t1");

    clear_logs();
    send(8'hC3, 8, 0);
    idle(1);
    check("t2_type", 32'(pkt_type), 32'h2);
    send(8'h55, 7, 0); send(8'h5A, 8, 0);
    idle(2);
    check("t2_ferr", 32'(n_ferr), 32'd1);
    check("t2_nwr", 32'(wr_log.size()), 32'd0);
    check("t2_ba", 32'(n_ba), 32'd2);
    check("t2_type_after", 32'(pkt_type), 32'h0);

    clear_logs();
    send(8'h3C, 8, 0); send(8'h11, 8, 0);
    idle(2);
    check("t3_type", 32'(pkt_type), 32'h0);
    check("t3_nwr", 32'(wr_log.size()), 32'd0);
    check("t3_ba", 32'(n_ba), 32'd2);

    clear_logs();
    send(8'hA5, 8, 0); send(8'h11, 8, 0); send(8'h22, 8, 1); send(8'h33, 8, 0); send(8'h44, 8, 0);
    trailer(8'h4F);
    idle(2);
    check("t4_nwr", 32'(wr_log.size()), 32'd3);
    check("t4_ovf", 32'(ovf_err), 32'h1);
    check("t4_done", 32'(n_done), 32'd1);
    send(8'h3C, 8, 0);
    idle(2);
    check("t4_ovf_sticky", 32'(ovf_err), 32'h1);

    send(8'hA5, 8, 0); send(8'h11, 8, 0); send(8'h22, 8, 0);
    idle(1);
    chk_en = 1'b0;
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    model_reset();
    chk_en = 1'b1;
    check("t5_ovf", 32'(ovf_err), 32'h0);
    check("t5_type", 32'(pkt_type), 32'h0);
    check("t5_data", 32'(fifo_data), 32'h0);
    pkt1("t5");

`ifdef CTRL_BLK_CHECKSUM_EN
    clear_logs();
    send(8'hA5, 8, 0); send(8'h01, 8, 0); send(8'h02, 8, 0); send(8'h03, 8, 0); send(8'h04, 8, 0); send(8'hAF, 8, 0);
    idle(2);
    check("t6_nwr", 32'(wr_log.size()), 32'd4);
    check("t6_done", 32'(n_done), 32'd1);
    check("t6_chk", 32'(n_chk), 32'd0);
    clear_logs();
    send(8'hA5, 8, 0); send(8'h01, 8, 0); send(8'h02, 8, 0); send(8'h03, 8, 0); send(8'h04, 8, 0); send(8'hB0, 8, 0);
    idle(2);
    check("t6b_nwr", 32'(wr_log.size()), 32'd4);
    check("t6b_done", 32'(n_done), 32'd1);
    check("t6b_chk", 32'(n_chk), 32'd1);
`endif

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      w = (r < 2) ? 8'hA5 : (r < 4) ? 8'hC3 : 8'($urandom);
      r = $urandom_range(0, 11);
      n = (r == 0) ? 7 : (r == 1) ? $urandom_range(9, 12) : (r == 2) ? 1 : 8;
      send(w, n, $urandom_range(0, 4) == 0);
      idle($urandom_range(0, 2));
    end
    idle(2);

    send16(16'h00A5);
    check("t7_type", 32'(type16), 32'h1);
    send16(16'hBEEF);
    check("t7_wr", 32'(wr16), 32'h1);
    check("t7_data", 32'(data16), 32'hBEEF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
